// File: rtl/addsub_share_arb_pkg.sv
// Shared types, op encodings and the add/sub reference function for addsub_share_arb.
// Saturation is enabled by defining ADDSUB_SHARE_ARB_SAT_EN.
package addsub_share_arb_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam int unsigned MAX_W   = 32;
  localparam int unsigned MAX_IDW = 8;

  typedef struct packed {
    logic [MAX_IDW-1:0] id;
    logic [MAX_W-1:0]   data;
    logic               ovf;
  } rsp_t;

  typedef struct packed {
    logic [MAX_W-1:0] data;
    logic             ovf;
  } calc_t;

  // Operates on the low w bits of a/b; upper bits of the returned data are zero.
  function automatic calc_t addsub_calc(input logic [MAX_W-1:0] a,
                                        input logic [MAX_W-1:0] b,
                                        input logic             op,
                                        input logic             is_signed,
                                        input int unsigned      w);
    logic [MAX_W:0]   full;
    logic [MAX_W:0]   cy_sh;
    logic [MAX_W-1:0] mask;
    logic [MAX_W-1:0] aa;
    logic [MAX_W-1:0] bb;
    logic [MAX_W-1:0] res;
    logic [MAX_W-1:0] sa_sh;
    logic [MAX_W-1:0] sb_sh;
    logic [MAX_W-1:0] sr_sh;
    logic             sa;
    logic             sb;
    logic             sr;
    calc_t            c;
    mask  = (w >= MAX_W) ? '1 : ((MAX_W'(1) << w) - MAX_W'(1));
    aa    = a & mask;
    bb    = b & mask;
    full  = (op == OP_SUB) ? ({1'b0, aa} - {1'b0, bb}) : ({1'b0, aa} + {1'b0, bb});
    res   = full[MAX_W-1:0] & mask;
    // Bit w of the widened result is carry for add and borrow for sub.
    cy_sh = full >> w;
    sa_sh = aa >> (w - 1);
    sb_sh = bb >> (w - 1);
    sr_sh = res >> (w - 1);
    sa    = sa_sh[0];
    sb    = sb_sh[0];
    sr    = sr_sh[0];
    if (is_signed) begin
      c.ovf = (op == OP_SUB) ? ((sa != sb) && (sr != sa)) : ((sa == sb) && (sr != sa));
    end else begin
      c.ovf = cy_sh[0];
    end
    c.data = res;
`ifdef ADDSUB_SHARE_ARB_SAT_EN
    if (c.ovf) begin
      if (is_signed) begin
        c.data = sa ? (MAX_W'(1) << (w - 1)) : (mask >> 1);
      end else begin
        c.data = (op == OP_SUB) ? '0 : mask;
      end
    end
`endif
    return c;
  endfunction

endpackage

// File: rtl/addsub_share_arb_rr_arbiter.sv
// Round-robin arbiter owning the rotating priority pointer; grants only when enabled.
module addsub_share_arb_rr_arbiter #(
  parameter int unsigned  NREQ = 4,
  localparam int unsigned IDW  = $clog2(NREQ)
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic [NREQ-1:0] i_req,
  input  logic            i_en,
  output logic [NREQ-1:0] o_gnt,
  output logic [IDW-1:0]  o_gnt_idx,
  output logic            o_gnt_valid
);

  logic [IDW-1:0] r_ptr;
  logic [IDW-1:0] w_ptr_d;
  logic [IDW-1:0] w_idx;
  logic [IDW-1:0] w_cand_idx;
  logic           w_found;
  int unsigned    w_cand;

  always_comb begin
    w_found    = 1'b0;
    w_idx      = '0;
    w_cand     = 0;
    w_cand_idx = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      w_cand     = (32'(r_ptr) + k) % NREQ;
      w_cand_idx = IDW'(w_cand);
      if (!w_found && i_req[w_cand_idx]) begin
        w_found = 1'b1;
        w_idx   = w_cand_idx;
      end
    end
  end

  always_comb begin
    o_gnt = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      o_gnt[k] = w_found && i_en && (w_idx == IDW'(k));
    end
  end

  assign o_gnt_idx   = w_idx;
  assign o_gnt_valid = w_found && i_en;
  assign w_ptr_d     = (w_idx == IDW'(NREQ - 1)) ? '0 : w_idx + 1'b1;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_ptr <= '0;
    end else if (w_found && i_en) begin
      r_ptr <= w_ptr_d;
    end
  end

endmodule

// File: rtl/addsub_share_arb.sv
// One shared add/sub unit arbitrated round-robin across NREQ requesters, 1-cycle latency.
// Define ADDSUB_SHARE_ARB_SAT_EN to clamp overflowing results instead of wrapping.
module addsub_share_arb
  import addsub_share_arb_pkg::*;
#(
  parameter int unsigned  NREQ = 4,
  parameter int unsigned  W    = 8,
  localparam int unsigned IDW  = $clog2(NREQ)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [NREQ-1:0]   i_req_valid,
  output logic [NREQ-1:0]   o_req_ready,
  input  logic [NREQ-1:0]   i_req_op,
  input  logic [NREQ-1:0]   i_req_signed,
  input  logic [NREQ*W-1:0] i_req_a,
  input  logic [NREQ*W-1:0] i_req_b,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [IDW-1:0]    o_rsp_id,
  output logic [W-1:0]      o_rsp_data,
  output logic              o_rsp_ovf
);

  logic           w_advance;
  logic           w_en;
  logic           w_gnt_valid;
  logic [IDW-1:0] w_gnt_idx;
  logic [W-1:0]   w_a;
  logic [W-1:0]   w_b;
  logic           w_op;
  logic           w_sgn;
  calc_t          w_calc;
  logic           r_rsp_valid;
  rsp_t           r_rsp;
  logic           w_unused;

  // Gating on reset keeps req_ready low while reset is held, without waiting for a clock.
  assign w_advance = !r_rsp_valid || i_rsp_ready;
  assign w_en      = w_advance && !i_reset;

  addsub_share_arb_rr_arbiter #(
    .NREQ(NREQ)
  ) u_arb (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_req      (i_req_valid),
    .i_en       (w_en),
    .o_gnt      (o_req_ready),
    .o_gnt_idx  (w_gnt_idx),
    .o_gnt_valid(w_gnt_valid)
  );

  assign w_a    = i_req_a[w_gnt_idx*W +: W];
  assign w_b    = i_req_b[w_gnt_idx*W +: W];
  assign w_op   = i_req_op[w_gnt_idx];
  assign w_sgn  = i_req_signed[w_gnt_idx];
  assign w_calc = addsub_calc(MAX_W'(w_a), MAX_W'(w_b), w_op, w_sgn, W);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_rsp_valid <= 1'b0;
      r_rsp       <= '0;
    end else if (w_advance) begin
      r_rsp_valid <= w_gnt_valid;
      if (w_gnt_valid) begin
        r_rsp.id   <= MAX_IDW'(w_gnt_idx);
        r_rsp.data <= w_calc.data;
        r_rsp.ovf  <= w_calc.ovf;
      end
    end
  end

  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_id    = r_rsp.id[IDW-1:0];
  assign o_rsp_data  = r_rsp.data[W-1:0];
  assign o_rsp_ovf   = r_rsp.ovf;

  // Register fields are sized for the widest configuration; upper bits stay zero.
  assign w_unused = ^{r_rsp.id, r_rsp.data};

endmodule
